// File: rtl/icache_pkg.sv
// Shared constants and state encoding for the instruction cache.
// Also used by the data-cache path through icache_word_select.
package icache_pkg;

  localparam int ICACHE_TAG_W = 3;
  localparam int ICACHE_IDX_W = 3;
  localparam int ICACHE_OFF_W = 2;
  localparam int BLOCK_W      = 128;
  localparam int WORD_W       = 32;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } icache_state_t;

endpackage

// File: rtl/icache_word_select.sv
// 128->32 offset multiplexer: picks word[offset] out of a cache block.
// Ports: block (line data), offset (word index), word (selected word).
module icache_word_select
  import icache_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic [BLOCK_W-1:0]      block,
  input  logic [ICACHE_OFF_W-1:0] offset,
  output logic [WORD_W-1:0]       word
);

  always_comb begin
    word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (offset == ICACHE_OFF_W'(k)) begin
        word = block[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only I-cache: 8 lines x 128 bits, same-cycle hits.
// Ports: CLK/RESET, ADDRESS->INSTRUCTION/BUSYWAIT, MEM_* block fetch.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int NUM_BLOCKS      = 8,
  parameter int WORDS_PER_BLOCK = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  output logic [WORD_W-1:0]     INSTRUCTION,
  output logic                  BUSYWAIT,
  output logic                  MEM_READ,
  output logic [ADDR_WIDTH-5:0] MEM_ADDRESS,
  input  logic [BLOCK_W-1:0]    MEM_READDATA,
  input  logic                  MEM_BUSYWAIT
);

  logic [BLOCK_W-1:0]      data_q [NUM_BLOCKS];
  logic [ICACHE_TAG_W-1:0] tag_q  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]   valid_q;

  icache_state_t state_q;
  icache_state_t state_d;

  logic [ICACHE_TAG_W-1:0] tag;
  logic [ICACHE_IDX_W-1:0] idx;
  logic [ICACHE_OFF_W-1:0] off;
  logic                    addr_unused;

  assign tag = ADDRESS[9:7];
  assign idx = ADDRESS[6:4];
  assign off = ADDRESS[3:2];
  assign addr_unused = ^ADDRESS[1:0];

  logic hit;
  logic busy;
  logic mem_rd;
  logic [WORD_W-1:0] word;

  assign hit = valid_q[idx] && (tag_q[idx] == tag);

  icache_word_select #(
    .WORDS (WORDS_PER_BLOCK)
  ) u_word_select (
    .block  (data_q[idx]),
    .offset (off),
    .word   (word)
  );

  // Data lands while still in MEM_READ; the line only becomes
  // visible once UPDATE writes tag and valid, so an abort
  // between the two leaves nothing usable behind.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_MEM_READ && !MEM_BUSYWAIT) begin
        data_q[idx] <= MEM_READDATA;
      end
      if (state_q == S_UPDATE) begin
        tag_q[idx]   <= tag;
        valid_q[idx] <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    mem_rd  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy = !hit;
        if (!hit) state_d = S_MEM_READ;
      end
      S_MEM_READ: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (!MEM_BUSYWAIT) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        busy    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held.
  assign BUSYWAIT    = busy & ~RESET;
  assign MEM_READ    = mem_rd & ~RESET;
  assign MEM_ADDRESS = ADDRESS[9:4];
  assign INSTRUCTION = RESET ? '0 : word;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Self-checking bench for icache_direct_mapped.
// Scoreboard of expected fetch words, latency-modelled memory.
module tb_icache_direct_mapped;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [9:0]   ADDRESS = '0;
  logic [31:0]  INSTRUCTION;
  logic         BUSYWAIT;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READDATA = '0;
  logic         MEM_BUSYWAIT = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q [$];

  localparam int MEM_LAT = 5;
  int mem_cnt = 0;

  icache_direct_mapped dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ADDRESS      (ADDRESS),
    .INSTRUCTION  (INSTRUCTION),
    .BUSYWAIT     (BUSYWAIT),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READDATA (MEM_READDATA),
    .MEM_BUSYWAIT (MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem_word(
    input logic [5:0] blk, input logic [1:0] k);
    return 32'hC0DE0000 | {24'd0, blk, k};
  endfunction

  function automatic logic [127:0] mem_block(
    input logic [5:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2),
            mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  // Memory: busy for MEM_LAT cycles, then one cycle with data.
  // Readdata is all-ones while busy to expose early captures.
  always @(negedge CLK) begin
    if (MEM_READ) begin
      if (mem_cnt < MEM_LAT) begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READDATA = '1;
        mem_cnt++;
      end else begin
        MEM_BUSYWAIT = 1'b0;
        MEM_READDATA = mem_block(MEM_ADDRESS);
        mem_cnt = 0;
      end
    end else begin
      MEM_BUSYWAIT = 1'b0;
      mem_cnt = 0;
    end
  end

  // The CPU must hold PC while stalled.
  logic [9:0] last_addr = '0;
  bit last_busy = 1'b0;
  always @(negedge CLK) begin
    if (last_busy) begin
      assert (ADDRESS == last_addr)
      else $error("FAIL addr_hold got=%h want=%h",
                  ADDRESS, last_addr);
    end
    last_busy = BUSYWAIT;
    last_addr = ADDRESS;
  end

  // Present one fetch; observe until BUSYWAIT falls.
  task automatic access(
    input  logic [9:0]  a,
    input  bit          release_rst,
    output logic [31:0] instr,
    output int          busy_cyc,
    output int          rd_cyc,
    output logic [5:0]  rd_addr,
    output bit          timeout);
    @(posedge CLK);
    #1;
    ADDRESS = a;
    if (release_rst) RESET = 1'b0;
    exp_q.push_back(mem_word(a[9:4], a[3:2]));
    busy_cyc = 0;
    rd_cyc = 0;
    rd_addr = '0;
    timeout = 1'b0;
    @(negedge CLK);
    while (BUSYWAIT) begin
      busy_cyc++;
      if (MEM_READ) begin
        rd_cyc++;
        rd_addr = MEM_ADDRESS;
      end
      if (busy_cyc > 60) begin
        timeout = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    instr = INSTRUCTION;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    ADDRESS = 10'h000;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (BUSYWAIT !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy got=%b want=0", BUSYWAIT);
    end
    checks++;
    if (MEM_READ !== 1'b0) begin
      failures++;
      $display("FAIL rst_mem_read got=%b want=0", MEM_READ);
    end
    checks++;
    if (INSTRUCTION !== 32'h0) begin
      failures++;
      $display("FAIL rst_instr got=%h want=0", INSTRUCTION);
    end
  endtask

  task automatic test_cold_miss();
    logic [31:0] ins, exp;
    int bc, rc;
    logic [5:0] ra;
    bit to;
    access(10'h000, 1'b1, ins, bc, rc, ra, to);
    exp = exp_q.pop_front();
    checks++;
    if (to) begin
      failures++;
      $display("FAIL cold_timeout got=busy want=done");
    end
    checks++;
    if (bc != 8) begin
      failures++;
      $display("FAIL cold_busy_cycles got=%0d want=8", bc);
    end
    checks++;
    if (rc != 6) begin
      failures++;
      $display("FAIL cold_read_cycles got=%0d want=6", rc);
    end
    checks++;
    if (ra !== 6'd0) begin
      failures++;
      $display("FAIL cold_mem_addr got=%0d want=0", ra);
    end
    checks++;
    if (ins !== exp) begin
      failures++;
      $display("FAIL cold_instr got=%h want=%h", ins, exp);
    end
  endtask

  task automatic test_seq_hits();
    logic [31:0] ins, exp;
    int bc, rc;
    logic [5:0] ra;
    bit to;
    for (int i = 1; i < 4; i++) begin
      access(10'(i * 4), 1'b0, ins, bc, rc, ra, to);
      exp = exp_q.pop_front();
      checks++;
      if (bc != 0) begin
        failures++;
        $display("FAIL hit_busy[%0d] got=%0d want=0", i, bc);
      end
      checks++;
      if (rc != 0) begin
        failures++;
        $display("FAIL hit_read[%0d] got=%0d want=0", i, rc);
      end
      checks++;
      if (ins !== exp) begin
        failures++;
        $display("FAIL hit_instr[%0d] got=%h want=%h",
                 i, ins, exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic [9:0] addrs [2];
    logic [31:0] ins, exp;
    int bc, rc;
    logic [5:0] ra;
    bit to;
    addrs[0] = 10'h080;
    addrs[1] = 10'h000;
    for (int i = 0; i < 2; i++) begin
      access(addrs[i], 1'b0, ins, bc, rc, ra, to);
      exp = exp_q.pop_front();
      checks++;
      if (to || bc == 0) begin
        failures++;
        $display("FAIL conf_miss[%0d] got=%0d want=miss", i, bc);
      end
      checks++;
      if (ra !== addrs[i][9:4]) begin
        failures++;
        $display("FAIL conf_mem_addr[%0d] got=%0d want=%0d",
                 i, ra, addrs[i][9:4]);
      end
      checks++;
      if (ins !== exp) begin
        failures++;
        $display("FAIL conf_instr[%0d] got=%h want=%h",
                 i, ins, exp);
      end
    end
  endtask

  // Fetch trace of a small loop: 2-instr prologue, then a
  // 6-instr body (0x08..0x1C) taken 6 times via BNE.
  task automatic test_loop_reuse();
    logic [31:0] ins, exp;
    int bc, rc;
    logic [5:0] ra;
    bit to;
    int miss_b0, miss_b1, bad;
    logic [9:0] pc;
    miss_b0 = 0;
    miss_b1 = 0;
    bad = 0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    access(10'h000, 1'b1, ins, bc, rc, ra, to);
    exp = exp_q.pop_front();
    if (bc > 0) miss_b0++;
    if (to || ins !== exp) bad++;
    access(10'h004, 1'b0, ins, bc, rc, ra, to);
    exp = exp_q.pop_front();
    if (bc > 0) miss_b0++;
    if (to || ins !== exp) bad++;
    for (int it = 0; it < 6; it++) begin
      for (int j = 0; j < 6; j++) begin
        pc = 10'(8 + 4 * j);
        access(pc, 1'b0, ins, bc, rc, ra, to);
        exp = exp_q.pop_front();
        if (bc > 0) begin
          if (pc[9:4] == 6'd0) miss_b0++;
          else miss_b1++;
        end
        if (to || ins !== exp) bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL loop_instr got=%0d_bad want=0", bad);
    end
    checks++;
    if (miss_b0 != 1) begin
      failures++;
      $display("FAIL loop_miss_b0 got=%0d want=1", miss_b0);
    end
    checks++;
    if (miss_b1 != 1) begin
      failures++;
      $display("FAIL loop_miss_b1 got=%0d want=1", miss_b1);
    end
  endtask

  task automatic test_reset_mid_miss();
    logic [31:0] ins, exp;
    int bc, rc;
    logic [5:0] ra;
    bit to;
    @(posedge CLK);
    #1;
    ADDRESS = 10'h040;
    @(negedge CLK);
    checks++;
    if ({BUSYWAIT, MEM_READ} !== 2'b10) begin
      failures++;
      $display("FAIL mid_idle got=%b want=10",
               {BUSYWAIT, MEM_READ});
    end
    repeat (3) @(negedge CLK);
    checks++;
    if (MEM_READ !== 1'b1) begin
      failures++;
      $display("FAIL mid_read3 got=%b want=1", MEM_READ);
    end
    RESET = 1'b1;
    #1;
    checks++;
    if ({BUSYWAIT, MEM_READ} !== 2'b00 ||
        INSTRUCTION !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst_out got=%b/%h want=00/0",
               {BUSYWAIT, MEM_READ}, INSTRUCTION);
    end
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if ({BUSYWAIT, MEM_READ} !== 2'b10) begin
      failures++;
      $display("FAIL mid_after got=%b want=10",
               {BUSYWAIT, MEM_READ});
    end
    access(10'h040, 1'b0, ins, bc, rc, ra, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || rc != 6) begin
      failures++;
      $display("FAIL mid_refetch got=%0d want=6", rc);
    end
    checks++;
    if (ins !== exp) begin
      failures++;
      $display("FAIL mid_instr got=%h want=%h", ins, exp);
    end
    access(10'h000, 1'b0, ins, bc, rc, ra, to);
    exp = exp_q.pop_front();
    checks++;
    if (to || bc == 0) begin
      failures++;
      $display("FAIL mid_b0_invalid got=%0d want=miss", bc);
    end
    checks++;
    if (ins !== exp) begin
      failures++;
      $display("FAIL mid_b0_instr got=%h want=%h", ins, exp);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ins, exp;
    logic [127:0] blk;
    int bc, rc;
    logic [5:0] ra;
    bit to;
    logic [31:0] pc32;
    pc32 = 32'hFFFF_FFFC;
    access(pc32[9:0], 1'b0, ins, bc, rc, ra, to);
    exp = exp_q.pop_front();
    blk = mem_block(6'd63);
    checks++;
    if (to || bc == 0) begin
      failures++;
      $display("FAIL wrap_miss got=%0d want=miss", bc);
    end
    checks++;
    if (ra !== 6'd63) begin
      failures++;
      $display("FAIL wrap_mem_addr got=%0d want=63", ra);
    end
    checks++;
    if (ins !== blk[127:96] || ins !== exp) begin
      failures++;
      $display("FAIL wrap_instr got=%h want=%h",
               ins, blk[127:96]);
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_seq_hits();
    test_conflict();
    test_loop_reuse();
    test_reset_mid_miss();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
- Instruction cache between the CPU fetch port (PC) and the 1 KB instruction memory. It supplies the instruction word at the current PC.
- Direct-mapped, 8 blocks of 16 bytes (4 instructions each), read-only.
- Hits return in the same cycle.
- Misses stall the CPU through BUSYWAIT while one 128-bit block is fetched from instruction memory.

Parameters:
- ADDR_WIDTH, 10, byte address width into instruction memory. PC[9:0] is used.
- NUM_BLOCKS, 8, number of cache lines. Index width is log2 = 3.
- WORDS_PER_BLOCK, 4, 32-bit instructions per line. Block is 128 bits; offset is PC[3:2].

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- ADDRESS  in  10  byte address of the instruction (PC[9:0]). Bits [1:0] are ignored.
- INSTRUCTION  out  32  instruction word. Valid when BUSYWAIT=0.
- BUSYWAIT  out  1  stall request to the CPU. The CPU must hold PC while this is high.
- MEM_READ  out  1  block read request to instruction memory.
- MEM_ADDRESS  out  6  block address to memory, equal to ADDRESS[9:4].
- MEM_READDATA  in  128  fetched block. Instruction at offset k occupies bits [32k+31:32k].
- MEM_BUSYWAIT  in  1  memory busy. The block is valid in the cycle MEM_BUSYWAIT falls to 0 while MEM_READ=1.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; it is sampled only on a rising CLK edge.
- Address split:
  - tag = ADDRESS[9:7] (3 bits)
  - index = ADDRESS[6:4]
  - offset = ADDRESS[3:2]
- Storage per line: data[127:0], tag[2:0], valid. There is no dirty bit (read-only).
- Hit: valid[index] && tag[index]==ADDRESS tag, evaluated combinationally.
- States: IDLE, MEM_READ, UPDATE.
- IDLE:
  - INSTRUCTION = data[index] word[offset], combinationally.
  - BUSYWAIT = !hit, combinationally. A miss therefore stalls in the same cycle the address arrives.
  - MEM_READ = 0.
  - On a miss, next state is MEM_READ.
- MEM_READ:
  - MEM_READ=1, MEM_ADDRESS=ADDRESS[9:4], BUSYWAIT=1.
  - Remain while MEM_BUSYWAIT=1.
  - When MEM_BUSYWAIT=0, capture MEM_READDATA into the line and go to UPDATE.
- UPDATE (one cycle):
  - Write tag, set valid, BUSYWAIT=1, MEM_READ=0.
  - Next state IDLE. The access then hits, and BUSYWAIT falls combinationally in that IDLE cycle.
- Miss latency: 1 cycle (MEM_READ entry) + memory cycles + 1 (UPDATE) before BUSYWAIT=0.
- Reset values:
  - state=IDLE and all valid=0, taking effect on the first rising edge with RESET=1.
  - While RESET=1: BUSYWAIT=0, MEM_READ=0, INSTRUCTION=32'h0.
  - Data and tag arrays are not reset.
- Reset during MEM_READ or UPDATE:
  - Abort; no line is written and all valid bits are cleared.
  - MEM_READ drops after that edge.
  - Instruction memory must tolerate MEM_READ deassertion mid-access.
- ADDRESS change while BUSYWAIT=1 is illegal; the CPU must hold PC. The bench asserts this.
- Conflict miss (same index, different tag): overwrite the line with no write-back.
- A stale INSTRUCTION value while BUSYWAIT=1 is permitted. The CPU must not consume it.
- Output ordering: INSTRUCTION and BUSYWAIT are purely combinational from state/arrays/ADDRESS. MEM_READ and MEM_ADDRESS are derived from state and ADDRESS only.
- Address wrap: only 10 bits are used, so a PC of 32'hFFFFFFFC maps to 0x3FC (tag 7, index 7, offset 3).

Decomposition:
- Shared package (icache_pkg), holding constants:
  - ICACHE_TAG_W=3, ICACHE_IDX_W=3, ICACHE_OFF_W=2, BLOCK_W=128
  - state encoding: IDLE=2'd0, MEM_READ=2'd1, UPDATE=2'd2
- One sub-module: icache_word_select, a 128→32 offset multiplexer reused by the data-cache path.
- Controller and arrays stay in icache_direct_mapped.

Test Plan:
- Cold miss:
  - Stimulus: RESET pulse, then ADDRESS=0x000; memory returns block 0 = {i3,i2,i1,i0} after 5 busy cycles.
  - Response: BUSYWAIT=1 from the first cycle. MEM_READ=1 with MEM_ADDRESS=6'd0 until MEM_BUSYWAIT falls. One UPDATE cycle follows, then BUSYWAIT=0 and INSTRUCTION=i0.
- Sequential hits:
  - Stimulus: after the cold miss, ADDRESS=0x004, 0x008, 0x00C.
  - Response: BUSYWAIT stays 0, MEM_READ stays 0, INSTRUCTION=i1, i2, i3 in successive cycles.
- Conflict miss:
  - Stimulus: ADDRESS=0x080 (index 0, tag 1), then 0x000.
  - Response: both accesses miss, with MEM_ADDRESS=6'd8 then 6'd0. After each fill, INSTRUCTION equals word 0 of the respective block.
- Loop reuse:
  - Stimulus: run the cpu_tb BNE/MULT loop program through the cache.
  - Response: exactly one miss for block 0 and one for block 1 over the whole run. Final r0=64, identical to the uncached run.
- Reset mid-miss:
  - Stimulus: assert RESET for 1 cycle in the 3rd MEM_READ cycle.
  - Response: MEM_READ=0 after the edge, all valid=0. Re-access to 0x000 misses again.
- Wrap:
  - Stimulus: ADDRESS=0x3FC.
  - Response: miss with MEM_ADDRESS=6'd63. INSTRUCTION is MEM_READDATA[127:96].
